phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Parametrised successor to the fixed system clock divider. Derives the CPU, memory and N auxiliary (video etc.) phase clocks from CLOCK_50.
- Adds run/halt control and single-step of whole CPU cycles.
- Adds one-cycle edge strobes so downstream logic can use CLOCK_50 plus enables instead of derived clocks.
- Sits at the top level and feeds the CPU, memory and video blocks.

Parameters:
- QUARTER, 100000: CLOCK_50 cycles per memory half-phase tick; must be >= 2.
- MEM_TICKS, 4: ticks per CPU half-cycle; must be even and >= 2, so mem_phi returns to its reset level at every CPU edge.
- NUM_AUX, 1: number of auxiliary phase outputs, >= 1.
- AUX_INVERT, all ones (NUM_AUX bits): bit i=1 makes aux_phi[i] = ~cpu_phi, bit i=0 makes aux_phi[i] = cpu_phi.

Ports:
- CLOCK_50 input 1: system clock, all logic on its rising edge.
- reset_n input 1: asynchronous, active-low reset.
- run input 1: level; 1 = free-run, 0 = halt at the next CPU falling edge.
- step input 1: single-cycle pulse; requests one full CPU cycle while halted.
- cpu_phi output 1: CPU phase clock.
- mem_phi output 1: memory phase clock, MEM_TICKS/2 periods per CPU half-cycle.
- aux_phi output NUM_AUX: auxiliary phases locked to cpu_phi.
- cpu_rise output 1: high for one cycle, the same cycle cpu_phi goes 0->1.
- cpu_fall output 1: high for one cycle, the same cycle cpu_phi goes 1->0.
- mem_edge output 1: high for one cycle, the same cycle mem_phi toggles.
- halted output 1: 1 while the state is HALTED.

Behaviour:
- Reset values (asynchronous):
  - cpu_phi=0, mem_phi=1, aux_phi[i]=AUX_INVERT[i].
  - All strobes 0, halted=1, state HALTED.
  - Prescaler=0, tick counter=0.
- Prescaler counts 0..QUARTER-1 only in RUNNING or STEPPING. "tick" = prescaler equal to QUARTER-1; the prescaler wraps to 0 on tick.
- On each tick:
  - mem_phi toggles and mem_edge=1.
  - Tick counter increments modulo MEM_TICKS.
  - When it wraps to 0, cpu_phi and all aux_phi toggle in the same cycle, and cpu_rise or cpu_fall asserts.
- All outputs are registered. Strobes coincide with the output change, not one cycle before it.
- Steady run: mem_phi period = 2*QUARTER cycles; cpu_phi period = 2*MEM_TICKS*QUARTER cycles, 50% duty.
- State machine:
  - HALTED: counters held at 0, outputs held.
    - run=1 -> RUNNING.
    - else step=1 -> STEPPING.
    - run and step both 1 -> RUNNING; the step is dropped.
  - RUNNING: on the cycle cpu_fall asserts, run=0 -> HALTED, else stay. A run drop mid-cycle never truncates a phase.
  - STEPPING: on the cycle cpu_fall asserts, -> RUNNING if run=1, else HALTED. A step therefore produces exactly one cpu_rise and one cpu_fall.
  - step is ignored in RUNNING and STEPPING; there is no queueing.
- Timing after leaving HALTED: the prescaler starts on the following cycle. The first tick is QUARTER cycles after the cycle in which the state changed.
- halted is registered from the state and reads 1 in the same cycle the state is HALTED.
- Reset asserted mid-operation: immediate return to reset values. No strobe fires on the reset edge.
- Halt always occurs with cpu_phi=0 and mem_phi=1, so the design resumes from the reset phase relationship.

Decomposition:
- phase_sequencer_pkg:
  - state typedef: enum HALTED, RUNNING, STEPPING.
  - Function computing the counter width, $clog2 with a minimum of 1.
- One sub-module, tick_prescaler:
  - Parameter QUARTER; ports CLOCK_50, reset_n, en, tick.
  - Counter held at 0 when en=0.
  - Instantiated once. Tick counter, FSM and phase registers live in the top module.

Test Plan (QUARTER=2, MEM_TICKS=4, NUM_AUX=2, AUX_INVERT=2'b01):
- Reset with run=0 held for 20 cycles -> cpu_phi=0, mem_phi=1, aux_phi=2'b01, halted=1, no strobes.
- Raise run -> halted drops the next cycle.
  - First mem_edge 2 cycles later; mem_phi toggles every 2 cycles.
  - cpu_rise on the 4th mem_edge; cpu_phi period 16 cycles; aux_phi[0]=~cpu_phi and aux_phi[1]=cpu_phi on every cycle.
- While running, drop run 1 cycle after cpu_rise -> running continues to cpu_fall (8 cycles after cpu_rise), then HALTED with cpu_phi=0, mem_phi=1.
- While halted, a 1-cycle step -> exactly one cpu_rise, one cpu_fall and 8 mem_edge pulses over 16 cycles, then halted=1. A second step pulsed mid-cycle has no effect.
- run=1 and step=1 in the same cycle while halted -> free-run, with no single-step halt after the first cpu_fall.
- Assert reset_n low mid-phase while cpu_phi=1 -> all outputs return to reset values asynchronously, before the next CLOCK_50 edge. No cpu_fall strobe.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared state type and sizing helper for the phase sequencer and its prescaler.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    HALTED,
    RUNNING,
    STEPPING
  } seq_state_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLOCK_50 down to a one-cycle tick every QUARTER cycles while enabled.
module tick_prescaler
  import phase_sequencer_pkg::*;
#(
  parameter int QUARTER = 100000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_width(QUARTER);
  localparam logic [W-1:0] LAST = W'(QUARTER - 1);

  logic [W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// CPU, memory and auxiliary phase generator with run/halt, single-step and
// one-cycle edge strobes that coincide with each registered phase change.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int                 QUARTER    = 100000,
  parameter int                 MEM_TICKS  = 4,
  parameter int                 NUM_AUX    = 1,
  parameter logic [NUM_AUX-1:0] AUX_INVERT = '1
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               run,
  input  logic               step,
  output logic               cpu_phi,
  output logic               mem_phi,
  output logic [NUM_AUX-1:0] aux_phi,
  output logic               cpu_rise,
  output logic               cpu_fall,
  output logic               mem_edge,
  output logic               halted
);

  localparam int TW = cnt_width(MEM_TICKS);
  localparam logic [TW-1:0] TLAST = TW'(MEM_TICKS - 1);

  seq_state_t      state;
  logic            tick;
  logic            en;
  logic            cpu_edge;
  logic            fall_now;
  logic [TW-1:0]   tick_cnt;

  assign en       = (state != HALTED);
  assign cpu_edge = tick && (tick_cnt == TLAST);
  assign fall_now = cpu_edge && cpu_phi;

  tick_prescaler #(
    .QUARTER (QUARTER)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .en       (en),
    .tick     (tick)
  );

  // Halting only on a CPU falling edge leaves both counters at zero with
  // cpu_phi=0 and mem_phi=1, so a restart resumes the reset phase relationship.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HALTED;
      halted   <= 1'b1;
      tick_cnt <= '0;
      cpu_phi  <= 1'b0;
      mem_phi  <= 1'b1;
      aux_phi  <= AUX_INVERT;
      cpu_rise <= 1'b0;
      cpu_fall <= 1'b0;
      mem_edge <= 1'b0;
    end else begin
      cpu_rise <= 1'b0;
      cpu_fall <= 1'b0;
      mem_edge <= 1'b0;

      if (tick) begin
        mem_phi  <= ~mem_phi;
        mem_edge <= 1'b1;
        tick_cnt <= cpu_edge ? '0 : tick_cnt + 1'b1;
        if (cpu_edge) begin
          cpu_phi  <= ~cpu_phi;
          aux_phi  <= ~aux_phi;
          cpu_rise <= ~cpu_phi;
          cpu_fall <= cpu_phi;
        end
      end

      case (state)
        HALTED: begin
          if (run) begin
            state  <= RUNNING;
            halted <= 1'b0;
          end else if (step) begin
            state  <= STEPPING;
            halted <= 1'b0;
          end
        end
        RUNNING: begin
          if (fall_now && !run) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        STEPPING: begin
          if (fall_now) begin
            if (run) begin
              state <= RUNNING;
            end else begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
